// File: rtl/vram_arbiter_if.sv
// Bus bundle for vram_arbiter: display fetch port, CPU req/ack port and RAM port.
// slave = the arbiter; master = requesters plus RAM.
interface vram_arbiter_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8
);
  logic                  dispReq;
  logic [ADDR_WIDTH-1:0] dispAddr;
  logic                  dispGrant;
  logic                  dispValid;
  logic [DATA_WIDTH-1:0] dispData;

  logic                  cpuReq;
  logic                  cpuWe;
  logic [ADDR_WIDTH-1:0] cpuAddr;
  logic [DATA_WIDTH-1:0] cpuWData;
  logic                  cpuAck;
  logic [DATA_WIDTH-1:0] cpuRData;

  logic [ADDR_WIDTH-1:0] ramAddr;
  logic                  ramWe;
  logic [DATA_WIDTH-1:0] ramWData;
  logic [DATA_WIDTH-1:0] ramRData;

  modport slave (
    input  dispReq, dispAddr, cpuReq, cpuWe, cpuAddr, cpuWData, ramRData,
    output dispGrant, dispValid, dispData, cpuAck, cpuRData, ramAddr, ramWe, ramWData
  );

  modport master (
    output dispReq, dispAddr, cpuReq, cpuWe, cpuAddr, cpuWData, ramRData,
    input  dispGrant, dispValid, dispData, cpuAck, cpuRData, ramAddr, ramWe, ramWData
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has strict priority, CPU uses idle slots.
// Optional starvation guard enabled by defining VRAM_STARVE_GUARD_EN.
module vram_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 15
) (
  input  logic           clk,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("vram_arbiter: MAX_WAIT must be at least 1");
  end

  typedef enum logic {ARB, CPU_DONE} state_t;

  state_t                state_q, state_d;
  logic                  disp_valid_q, disp_valid_d;
  logic                  cpu_ack_q, cpu_ack_d;
  logic                  cpu_rd_q, cpu_rd_d;
  logic [DATA_WIDTH-1:0] disp_data_q, disp_data_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;

  logic cpu_elig, force_cpu, disp_gnt, cpu_gnt;
  logic disp_valid, cpu_ack;

  // CPU is blocked in CPU_DONE so a req still held during its ack cannot reissue.
  assign cpu_elig = bus.cpuReq && (state_q == ARB) && !reset;

`ifdef VRAM_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;

  assign force_cpu = cpu_elig && (wait_q == WAIT_W'(MAX_WAIT));

  always_comb begin
    wait_d = wait_q;
    if (cpu_gnt)
      wait_d = '0;
    else if (cpu_elig && (wait_q != WAIT_W'(MAX_WAIT)))
      wait_d = wait_q + WAIT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end
`else
  assign force_cpu = 1'b0;
`endif

  assign disp_gnt = bus.dispReq && !force_cpu;
  assign cpu_gnt  = cpu_elig && !disp_gnt;

  always_comb begin
    bus.ramAddr  = '0;
    bus.ramWe    = 1'b0;
    bus.ramWData = '0;
    if (disp_gnt) begin
      bus.ramAddr = bus.dispAddr;
    end else if (cpu_gnt) begin
      bus.ramAddr  = bus.cpuAddr;
      bus.ramWe    = bus.cpuWe;
      bus.ramWData = bus.cpuWData;
    end
  end

  always_comb begin
    state_d      = cpu_gnt ? CPU_DONE : ARB;
    disp_valid_d = disp_gnt;
    cpu_ack_d    = cpu_gnt;
    cpu_rd_d     = cpu_gnt && !bus.cpuWe;
    disp_data_d  = disp_valid ? bus.ramRData : disp_data_q;
    cpu_rdata_d  = (cpu_ack && cpu_rd_q) ? bus.ramRData : cpu_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB;
      disp_valid_q <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_rd_q     <= 1'b0;
      disp_data_q  <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      disp_valid_q <= disp_valid_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rd_q     <= cpu_rd_d;
      disp_data_q  <= disp_data_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  // Read data arrives the cycle after the grant, so it is forwarded straight from
  // the RAM while valid/ack is high and held in a register afterwards.
  assign disp_valid    = disp_valid_q && !reset;
  assign cpu_ack       = cpu_ack_q && !reset;
  assign bus.dispGrant = disp_gnt;
  assign bus.dispValid = disp_valid;
  assign bus.dispData  = disp_valid ? bus.ramRData : disp_data_q;
  assign bus.cpuAck    = cpu_ack;
  assign bus.cpuRData  = (cpu_ack && cpu_rd_q) ? bus.ramRData : cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM.
module tb_vram_arbiter;
  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;
  int   wr_cnt;
  logic [7:0] mem [0:16383];

  vram_arbiter_if #(.ADDR_WIDTH(14), .DATA_WIDTH(8)) bus ();

  vram_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(8), .MAX_WAIT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ramWe === 1'b1) begin
      mem[bus.ramAddr] <= bus.ramWData;
      wr_cnt <= wr_cnt + 1;
    end
    bus.ramRData <= mem[bus.ramAddr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int wr0;
  int ack_seen;
  int gnt_bad;

  initial begin
    pass_cnt = 0; total_cnt = 0; wr_cnt = 0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem[14'h1000 + i] = 8'(i);
    reset = 1'b1;
    bus.dispReq = 0; bus.dispAddr = '0;
    bus.cpuReq = 0; bus.cpuWe = 0; bus.cpuAddr = '0; bus.cpuWData = '0;

    // reset state
    tick(); tick(); #4;
    chk("rst_ack",   32'(bus.cpuAck), 0);
    chk("rst_valid", 32'(bus.dispValid), 0);
    chk("rst_we",    32'(bus.ramWe), 0);
    chk("rst_rdata", 32'(bus.cpuRData), 0);
    chk("rst_ddata", 32'(bus.dispData), 0);
    tick(); reset = 1'b0;

    // 1: CPU write 0x0123 = 0xA5
    tick(); bus.cpuReq = 1; bus.cpuWe = 1; bus.cpuAddr = 14'h0123; bus.cpuWData = 8'hA5; #4;
    chk("t1_we",    32'(bus.ramWe), 1);
    chk("t1_addr",  32'(bus.ramAddr), 32'h0123);
    chk("t1_wdata", 32'(bus.ramWData), 32'hA5);
    chk("t1_ack0",  32'(bus.cpuAck), 0);
    tick(); #4;
    chk("t1_ack",   32'(bus.cpuAck), 1);
    chk("t1_we_done", 32'(bus.ramWe), 0);
    tick(); bus.cpuReq = 0; #4;
    chk("t1_ack_end", 32'(bus.cpuAck), 0);
    chk("t1_we_idle", 32'(bus.ramWe), 0);

    // 2: CPU read back
    tick(); bus.cpuReq = 1; bus.cpuWe = 0; bus.cpuAddr = 14'h0123; #4;
    chk("t2_addr", 32'(bus.ramAddr), 32'h0123);
    chk("t2_we",   32'(bus.ramWe), 0);
    tick(); #4;
    chk("t2_ack",   32'(bus.cpuAck), 1);
    chk("t2_rdata", 32'(bus.cpuRData), 32'hA5);
    tick(); bus.cpuReq = 0; #4;
    chk("t2_ack_end",  32'(bus.cpuAck), 0);
    chk("t2_rdata_hold", 32'(bus.cpuRData), 32'hA5);

    // 3: display burst with CPU read raised mid-burst
    for (int i = 0; i < 8; i++) begin
      tick(); bus.dispReq = 1; bus.dispAddr = 14'h1000 + 14'(i);
      if (i == 3) begin bus.cpuReq = 1; bus.cpuWe = 0; bus.cpuAddr = 14'h0123; end
      #4;
      chk($sformatf("t3_grant%0d", i), 32'(bus.dispGrant), 1);
      chk($sformatf("t3_addr%0d", i), 32'(bus.ramAddr), 32'h1000 + i);
      chk($sformatf("t3_ack%0d", i), 32'(bus.cpuAck), 0);
      if (i == 0) chk("t3_valid0", 32'(bus.dispValid), 0);
      else begin
        chk($sformatf("t3_valid%0d", i), 32'(bus.dispValid), 1);
        chk($sformatf("t3_data%0d", i), 32'(bus.dispData), i - 1);
      end
    end
    tick(); bus.dispReq = 0; #4;
    chk("t3_valid_last", 32'(bus.dispValid), 1);
    chk("t3_data_last",  32'(bus.dispData), 7);
    chk("t3_dgrant_off", 32'(bus.dispGrant), 0);
    chk("t3_cpu_addr",   32'(bus.ramAddr), 32'h0123);
    tick(); #4;
    chk("t3_cpu_ack",   32'(bus.cpuAck), 1);
    chk("t3_cpu_rdata", 32'(bus.cpuRData), 32'hA5);
    chk("t3_valid_end", 32'(bus.dispValid), 0);
    tick(); bus.cpuReq = 0;

    // 4: cpuReq held across two writes, address changed in the ack cycle
    wr0 = wr_cnt;
    tick(); bus.cpuReq = 1; bus.cpuWe = 1; bus.cpuAddr = 14'h0200; bus.cpuWData = 8'h11; #4;
    chk("t4_we_a",   32'(bus.ramWe), 1);
    chk("t4_addr_a", 32'(bus.ramAddr), 32'h0200);
    tick(); #4;
    chk("t4_ack_a",  32'(bus.cpuAck), 1);
    chk("t4_we_gap", 32'(bus.ramWe), 0);
    bus.cpuAddr = 14'h0201; bus.cpuWData = 8'h22;
    tick(); #4;
    chk("t4_we_b",    32'(bus.ramWe), 1);
    chk("t4_addr_b",  32'(bus.ramAddr), 32'h0201);
    chk("t4_wdata_b", 32'(bus.ramWData), 32'h22);
    chk("t4_ack_gap", 32'(bus.cpuAck), 0);
    tick(); #4;
    chk("t4_ack_b", 32'(bus.cpuAck), 1);
    tick(); bus.cpuReq = 0; #4;
    chk("t4_ack_end", 32'(bus.cpuAck), 0);
    chk("t4_writes",  32'(wr_cnt - wr0), 2);
    chk("t4_mem_a",   32'(mem[14'h0200]), 32'h11);
    chk("t4_mem_b",   32'(mem[14'h0201]), 32'h22);

    // 5: reset in the cycle after a CPU grant
    tick(); bus.cpuReq = 1; bus.cpuWe = 0; bus.cpuAddr = 14'h1005; #4;
    chk("t5_addr", 32'(bus.ramAddr), 32'h1005);
    tick(); reset = 1; #4;
    chk("t5_ack_drop", 32'(bus.cpuAck), 0);
    tick(); bus.cpuReq = 0; #4;
    chk("t5_ack_rst",   32'(bus.cpuAck), 0);
    chk("t5_rdata_rst", 32'(bus.cpuRData), 0);
    chk("t5_ddata_rst", 32'(bus.dispData), 0);
    chk("t5_valid_rst", 32'(bus.dispValid), 0);
    chk("t5_we_rst",    32'(bus.ramWe), 0);
    tick(); reset = 0; bus.cpuReq = 1; #4;
    chk("t5_re_addr", 32'(bus.ramAddr), 32'h1005);
    tick(); #4;
    chk("t5_re_ack",   32'(bus.cpuAck), 1);
    chk("t5_re_rdata", 32'(bus.cpuRData), 32'h05);
    tick(); bus.cpuReq = 0;

    // 6: display held high constantly with a pending CPU read
    tick(); bus.dispReq = 1; bus.dispAddr = 14'h1000;
    bus.cpuReq = 1; bus.cpuWe = 0; bus.cpuAddr = 14'h1002;
`ifdef VRAM_STARVE_GUARD_EN
    ack_seen = 0; gnt_bad = 0;
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) tick();
      #4;
      if (bus.dispGrant !== 1'b1) gnt_bad++;
      if (bus.cpuAck !== 1'b0) ack_seen++;
    end
    chk("t6_denied_grants", 32'(gnt_bad), 0);
    chk("t6_early_ack",     32'(ack_seen), 0);
    tick(); #4;
    chk("t6_force_dgrant", 32'(bus.dispGrant), 0);
    chk("t6_force_addr",   32'(bus.ramAddr), 32'h1002);
    tick(); #4;
    chk("t6_force_ack",   32'(bus.cpuAck), 1);
    chk("t6_force_rdata", 32'(bus.cpuRData), 32'h02);
    chk("t6_dgrant_back", 32'(bus.dispGrant), 1);
`else
    ack_seen = 0; gnt_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) tick();
      #4;
      if (bus.dispGrant !== 1'b1) gnt_bad++;
      if (bus.cpuAck !== 1'b0) ack_seen++;
    end
    chk("t6_grants", 32'(gnt_bad), 0);
    chk("t6_no_ack", 32'(ack_seen), 0);
`endif
    tick(); bus.dispReq = 0; bus.cpuReq = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
